// File: rtl/display_0_99_if.sv
// Bundle of the BCD digit inputs, display controls and segment/digit outputs
// shared between the counter side (master) and the display driver (slave).
interface display_0_99_if;
  logic [3:0] unidades;
  logic [3:0] dezenas;
  logic       apagar_zero;
  logic       piscar;
  logic [6:0] seg;
  logic [1:0] dig;
  logic       erro;

  modport master (
    output unidades, dezenas, apagar_zero, piscar,
    input  seg, dig, erro
  );

  modport slave (
    input  unidades, dezenas, apagar_zero, piscar,
    output seg, dig, erro
  );
endinterface

// File: rtl/display_0_99.sv
// Two-digit multiplexed 7-segment driver: scans units then tens with a one-cycle
// blank gap between digits, plus leading-zero blanking, blinking and bad-BCD flag.
module display_0_99 #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 25
) (
  input logic           clock,
  input logic           reset,
  display_0_99_if.slave bus
);

  localparam int DW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {U_ON, U_GAP, D_ON, D_GAP} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [DW-1:0] r_divCnt;
  logic [FW-1:0] r_frmCnt;
  logic          r_fase;
  logic [3:0]    r_snapU;
  logic [3:0]    r_snapT;
  logic          r_erro;
  logic [6:0]    r_seg;
  logic [1:0]    r_dig;
  logic [6:0]    w_seg;
  logic [1:0]    w_dig;
  logic          w_divDone;
  logic          w_load;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111110;
    endcase
  endfunction

  assign w_divDone = (r_divCnt == DIV_LAST);
  assign w_load    = (r_state == D_GAP);

  always_ff @(posedge clock) begin
    if (reset) r_state <= D_GAP;
    else       r_state <= w_nextState;
  end

  // Next state and the values the output registers take at the next edge;
  // blink-off overrides everything else on the digit enables.
  always_comb begin
    w_nextState = r_state;
    w_seg       = 7'b1111111;
    w_dig       = 2'b11;
    case (r_state)
      U_ON: begin
        w_seg = decode(r_snapU);
        w_dig = 2'b10;
        if (w_divDone) w_nextState = U_GAP;
      end
      U_GAP: w_nextState = D_ON;
      D_ON: begin
        w_seg = decode(r_snapT);
        w_dig = (bus.apagar_zero && (r_snapT == 4'd0)) ? 2'b11 : 2'b01;
        if (w_divDone) w_nextState = D_GAP;
      end
      D_GAP: w_nextState = U_ON;
      default: w_nextState = D_GAP;
    endcase
    if (bus.piscar && r_fase) w_dig = 2'b11;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_divCnt <= '0;
      r_frmCnt <= '0;
      r_fase   <= 1'b0;
      r_snapU  <= 4'd0;
      r_snapT  <= 4'd0;
      r_erro   <= 1'b0;
      r_seg    <= 7'b1111111;
      r_dig    <= 2'b11;
    end else begin
      if ((r_state == U_ON) || (r_state == D_ON))
        r_divCnt <= w_divDone ? '0 : r_divCnt + DW'(1);
      else
        r_divCnt <= '0;

      if (w_load) begin
        r_snapU <= bus.unidades;
        r_snapT <= bus.dezenas;
        r_erro  <= (bus.unidades > 4'd9) || (bus.dezenas > 4'd9);
      end

      // Holding the blink counters at zero while idle makes every blink start visible.
      if (!bus.piscar) begin
        r_frmCnt <= '0;
        r_fase   <= 1'b0;
      end else if (w_load) begin
        if (r_frmCnt == FRM_LAST) begin
          r_frmCnt <= '0;
          r_fase   <= ~r_fase;
        end else begin
          r_frmCnt <= r_frmCnt + FW'(1);
        end
      end

      r_seg <= w_seg;
      r_dig <= w_dig;
    end
  end

  assign bus.seg  = r_seg;
  assign bus.dig  = r_dig;
  assign bus.erro = r_erro;

endmodule

// File: tb/tb_display_0_99.sv
// Self-checking bench for display_0_99: a frame-position reference model built
// from the scan rules predicts seg/dig/erro every cycle under random stimulus.
module tb_display_0_99;
  localparam int RD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 2 * RD + 2;
  localparam int LAST  = FRAME - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passCount  = 0;
  int   checkCount = 0;

  display_0_99_if bus ();

  display_0_99 #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [6:0] segTable [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

  function automatic logic [6:0] segOf(input logic [3:0] d);
    if (d > 4'd9) return 7'b1111110;
    return segTable[d];
  endfunction

  // Reference model: mPos is the position within the frame (0..RD-1 units lit,
  // RD gap, RD+1..2RD tens lit, LAST gap); mBlinkK counts frames since piscar rose.
  int         mPos    = LAST;
  int         mBlinkK = 0;
  logic [3:0] mSnapU  = 4'd0;
  logic [3:0] mSnapT  = 4'd0;
  logic [6:0] expSeg  = 7'b1111111;
  logic [1:0] expDig  = 2'b11;
  logic       expErro = 1'b0;

  always @(posedge clock) begin
    logic blinkOff;
    if (reset) begin
      expSeg = 7'b1111111; expDig = 2'b11; expErro = 1'b0;
      mPos = LAST; mBlinkK = 0; mSnapU = 4'd0; mSnapT = 4'd0;
    end else begin
      blinkOff = bus.piscar && (((mBlinkK / BF) % 2) == 1);
      if (mPos < RD) begin
        expSeg = segOf(mSnapU);
        expDig = blinkOff ? 2'b11 : 2'b10;
      end else if (mPos > RD && mPos <= 2 * RD) begin
        expSeg = segOf(mSnapT);
        expDig = (blinkOff || (bus.apagar_zero && mSnapT == 4'd0)) ? 2'b11 : 2'b01;
      end else begin
        expSeg = 7'b1111111;
        expDig = 2'b11;
      end
      if (!bus.piscar) mBlinkK = 0;
      else if (mPos == LAST) mBlinkK = mBlinkK + 1;
      if (mPos == LAST) begin
        mSnapU  = bus.unidades;
        mSnapT  = bus.dezenas;
        expErro = (bus.unidades > 4'd9) || (bus.dezenas > 4'd9);
      end
      mPos = (mPos + 1) % FRAME;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.unidades = 4'd7; bus.dezenas = 4'd3; bus.apagar_zero = 1'b0; bus.piscar = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      checkCount++;
      if (bus.seg !== 7'b1111111 || bus.dig !== 2'b11 || bus.erro !== 1'b0)
        $display("[TB] FAIL reset: seg=%b dig=%b erro=%b required 1111111/11/0", bus.seg, bus.dig, bus.erro);
      else passCount++;
    end
  endtask

  task automatic test_basic_scan();
    reset = 1'b0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      @(posedge clock); #1;
      checkCount++;
      if (bus.seg !== expSeg || bus.dig !== expDig || bus.erro !== expErro)
        $display("[TB] FAIL basic_scan c%0d: seg=%b dig=%b erro=%b required %b/%b/%b", i, bus.seg, bus.dig, bus.erro, expSeg, expDig, expErro);
      else passCount++;
      if (i == 2 || i == 7 || i == 6) begin
        checkCount++;
        if ((i == 2 && (bus.dig !== 2'b10 || bus.seg !== 7'b0001111)) ||
            (i == 6 && (bus.dig !== 2'b11 || bus.seg !== 7'b1111111)) ||
            (i == 7 && (bus.dig !== 2'b01 || bus.seg !== 7'b0000110)))
          $display("[TB] FAIL basic_slot c%0d: seg=%b dig=%b", i, bus.seg, bus.dig);
        else passCount++;
      end
    end
  endtask

  task automatic test_snapshot();
    bus.unidades = 4'd7;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge clock); #1;
      checkCount++;
      if (bus.seg !== expSeg || bus.dig !== expDig || bus.erro !== expErro)
        $display("[TB] FAIL snapshot c%0d: seg=%b dig=%b erro=%b required %b/%b/%b", i, bus.seg, bus.dig, bus.erro, expSeg, expDig, expErro);
      else passCount++;
      if (i >= FRAME && mPos == RD + 2 && bus.unidades == 4'd7) bus.unidades = 4'd2;
    end
  endtask

  task automatic test_leading_zero();
    bus.dezenas = 4'd0;
    bus.apagar_zero = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clock); #1;
      if (i == 2 * FRAME) bus.apagar_zero = 1'b0;
      checkCount++;
      if (bus.seg !== expSeg || bus.dig !== expDig || bus.erro !== expErro)
        $display("[TB] FAIL leading_zero c%0d: seg=%b dig=%b erro=%b required %b/%b/%b", i, bus.seg, bus.dig, bus.erro, expSeg, expDig, expErro);
      else passCount++;
      if (i > FRAME && i < 2 * FRAME) begin
        checkCount++;
        if (bus.dig === 2'b01) $display("[TB] FAIL blank_tens c%0d: dig=%b required not 01", i, bus.dig);
        else passCount++;
      end
    end
  endtask

  task automatic test_blink();
    bit dropped = 1'b0;
    bus.dezenas = 4'd4;
    bus.piscar  = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(posedge clock); #1;
      checkCount++;
      if (bus.seg !== expSeg || bus.dig !== expDig || bus.erro !== expErro)
        $display("[TB] FAIL blink c%0d: seg=%b dig=%b erro=%b required %b/%b/%b", i, bus.seg, bus.dig, bus.erro, expSeg, expDig, expErro);
      else passCount++;
      if (!dropped && i > 5 * FRAME && ((mBlinkK / BF) % 2) == 1 && mPos == 2) begin
        bus.piscar = 1'b0;
        dropped = 1'b1;
      end
    end
    checkCount++;
    if (!dropped) $display("[TB] FAIL blink_drop: off phase not reached (dropped=%0d required 1)", dropped);
    else passCount++;
  endtask

  task automatic test_invalid();
    bus.unidades = 4'hC;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clock); #1;
      checkCount++;
      if (bus.seg !== expSeg || bus.dig !== expDig || bus.erro !== expErro)
        $display("[TB] FAIL invalid c%0d: seg=%b dig=%b erro=%b required %b/%b/%b", i, bus.seg, bus.dig, bus.erro, expSeg, expDig, expErro);
      else passCount++;
    end
    checkCount++;
    if (bus.erro !== 1'b1) $display("[TB] FAIL invalid_erro: erro=%b required 1", bus.erro);
    else passCount++;
    bus.unidades = 4'd5;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clock); #1;
      checkCount++;
      if (bus.seg !== expSeg || bus.dig !== expDig || bus.erro !== expErro)
        $display("[TB] FAIL valid_again c%0d: seg=%b dig=%b erro=%b required %b/%b/%b", i, bus.seg, bus.dig, bus.erro, expSeg, expDig, expErro);
      else passCount++;
    end
    checkCount++;
    if (bus.erro !== 1'b0) $display("[TB] FAIL valid_erro: erro=%b required 0", bus.erro);
    else passCount++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      checkCount++;
      if (bus.seg !== expSeg || bus.dig !== expDig || bus.erro !== expErro)
        $display("[TB] FAIL random c%0d: seg=%b dig=%b erro=%b required %b/%b/%b", i, bus.seg, bus.dig, bus.erro, expSeg, expDig, expErro);
      else passCount++;
      if ($urandom_range(0, 6) == 0) begin
        bus.unidades = 4'($urandom_range(0, 15));
        bus.dezenas  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) bus.apagar_zero = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) bus.piscar = ~bus.piscar;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bus.piscar = 1'b0; bus.apagar_zero = 1'b0;
    bus.unidades = 4'hC; bus.dezenas = 4'd6;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(posedge clock); #1;
      if (i > FRAME && mPos == RD + 2) found = 1'b1;
    end
    checkCount++;
    if (!found || bus.erro !== 1'b1)
      $display("[TB] FAIL reset_mid_setup: found=%0d erro=%b required 1/1", found, bus.erro);
    else passCount++;
    reset = 1'b1;
    @(posedge clock); #1;
    checkCount++;
    if (bus.seg !== 7'b1111111 || bus.dig !== 2'b11 || bus.erro !== 1'b0)
      $display("[TB] FAIL reset_mid: seg=%b dig=%b erro=%b required 1111111/11/0", bus.seg, bus.dig, bus.erro);
    else passCount++;
    reset = 1'b0;
    @(posedge clock); #1;
    checkCount++;
    if (bus.seg !== 7'b1111111 || bus.dig !== 2'b11)
      $display("[TB] FAIL reset_gap: seg=%b dig=%b required 1111111/11", bus.seg, bus.dig);
    else passCount++;
    @(posedge clock); #1;
    checkCount++;
    if (bus.seg !== 7'b1111110 || bus.dig !== 2'b10 || bus.erro !== 1'b1)
      $display("[TB] FAIL reset_units: seg=%b dig=%b erro=%b required 1111110/10/1", bus.seg, bus.dig, bus.erro);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_leading_zero();
    test_blink();
    test_invalid();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
